// File: rtl/exe_stage_mdu_pkg.sv
// Shared encodings for the RV64 M-extension multiply/divide unit:
// funct3 op codes, op bus width, FSM state codes and op-decode helpers.
`ifndef EXE_STAGE_MDU_DEFS
`define EXE_STAGE_MDU_DEFS
`define MDU_OP_BUS   3
`define MDU_MUL      3'd0
`define MDU_MULH     3'd1
`define MDU_MULHSU   3'd2
`define MDU_MULHU    3'd3
`define MDU_DIV      3'd4
`define MDU_DIVU     3'd5
`define MDU_REM      3'd6
`define MDU_REMU     3'd7
`define MDU_ST_IDLE  2'd0
`define MDU_ST_MUL   2'd1
`define MDU_ST_DIV   2'd2
`define MDU_ST_DONE  2'd3
`endif

package exe_stage_mdu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = `MDU_ST_IDLE,
    ST_MUL  = `MDU_ST_MUL,
    ST_DIV  = `MDU_ST_DIV,
    ST_DONE = `MDU_ST_DONE
  } mdu_state_e;

  // funct3[2] separates the divide family from the multiply family.
  function automatic logic op_is_div(input logic [`MDU_OP_BUS-1:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input logic [`MDU_OP_BUS-1:0] op);
    return op[2] & op[1];
  endfunction

  // rs1 is signed for MUL, MULH, MULHSU, DIV and REM.
  function automatic logic op1_signed(input logic [`MDU_OP_BUS-1:0] op);
    return (op == `MDU_MUL) || (op == `MDU_MULH) || (op == `MDU_MULHSU) ||
           (op == `MDU_DIV) || (op == `MDU_REM);
  endfunction

  // rs2 is signed for MUL, MULH, DIV and REM.
  function automatic logic op2_signed(input logic [`MDU_OP_BUS-1:0] op);
    return (op == `MDU_MUL) || (op == `MDU_MULH) ||
           (op == `MDU_DIV) || (op == `MDU_REM);
  endfunction

endpackage

// File: rtl/exe_stage_mdu_div.sv
// Restoring divider datapath: one quotient bit per step on unsigned
// magnitudes. quo_o/rem_o expose the post-step values so the caller can
// capture the final result on the same edge as the last step.
module exe_stage_mdu_div #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic             step_i,
  input  logic [XLEN-1:0]  dividend_i,
  input  logic [XLEN-1:0]  divisor_i,
  input  logic [CNT_W-1:0] iters_i,
  output logic [XLEN-1:0]  quo_o,
  output logic [XLEN-1:0]  rem_o,
  output logic             last_o
);

  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  quo_q, quo_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN:0]    r_shift;
  logic [XLEN:0]    diff;
  logic             take;

  // One restoring step: shift in the next dividend bit, trial-subtract.
  always_comb begin
    r_shift = {rem_q, quo_q[XLEN-1]};
    diff    = r_shift - {1'b0, dvs_q};
    take    = ~diff[XLEN];
    quo_o   = {quo_q[XLEN-2:0], take};
    rem_o   = take ? diff[XLEN-1:0] : r_shift[XLEN-1:0];
    last_o  = step_i && (cnt_q == CNT_W'(1));
  end

  // Load on start, advance on step; otherwise hold.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (start_i) begin
      // Align the dividend so its bit iters_i-1 is the first one shifted in.
      rem_d = '0;
      quo_d = dividend_i << (CNT_W'(XLEN) - iters_i);
      dvs_d = divisor_i;
      cnt_d = iters_i;
    end else if (step_i) begin
      rem_d = rem_o;
      quo_d = quo_o;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Iteration counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst || clear_i) cnt_q <= '0;
    else                cnt_q <= cnt_d;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: no reset here on purpose; start_i always loads these before use.
    rem_q <= rem_d;
    quo_q <= quo_d;
    dvs_q <= dvs_d;
  end

endmodule

// File: rtl/exe_stage_mdu.sv
// Iterative multiply/divide unit for the RV64 execute stage (M extension,
// including *W forms). One op in flight, valid/ready on both sides, flush.
// Build option MDU_FAST_MUL_EN: single-cycle combinational multiplier for
// MUL* ops instead of the radix-2 shift-add loop.
module exe_stage_mdu
  import exe_stage_mdu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int WORD_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [`MDU_OP_BUS-1:0] op,
  input  logic                   is_word_opt,
  input  logic [XLEN-1:0]        op1,
  input  logic [XLEN-1:0]        op2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        result,
  output logic                   busy
);

  localparam int CNT_W = $clog2(XLEN + 1);

  // Extend the low WORD_W bits to XLEN, signed or unsigned.
  function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] v, input logic sgn);
    logic [XLEN-1:0] r;
    r = v;
    for (int i = WORD_W; i < XLEN; i++) r[i] = sgn & v[WORD_W-1];
    return r;
  endfunction

  // Word results are always sign-extended from bit WORD_W-1.
  function automatic logic [XLEN-1:0] fmt_result(input logic [XLEN-1:0] v, input logic word);
    return word ? word_ext(v, 1'b1) : v;
  endfunction

  function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] p,
                                               input logic [`MDU_OP_BUS-1:0] o);
    return (o == `MDU_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  mdu_state_e              state_q, state_d;
  logic                    out_valid_q, out_valid_d;
  logic [XLEN-1:0]         result_q, result_d;
  logic [`MDU_OP_BUS-1:0]  op_q, op_d;
  logic                    word_q, word_d;
  logic                    neg_q, neg_d;
  logic [2*XLEN-1:0]       acc_q, acc_d;
  logic [2*XLEN-1:0]       mcand_q, mcand_d;
  logic [XLEN-1:0]         mplier_q, mplier_d;
  logic [CNT_W-1:0]        mcnt_q, mcnt_d;

  logic [`MDU_OP_BUS-1:0]  eff_op;
  logic                    a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]         a_ext, b_ext, a_mag, b_mag, min_n;
  logic [CNT_W-1:0]        n_iter;
  logic                    div_zero, div_ovf, accept, div_start;
  logic [2*XLEN-1:0]       acc_sum, mul_prod;
  logic [XLEN-1:0]         div_quo, div_rem, div_raw, div_res;
  logic                    div_last;

  assign in_ready  = (state_q == ST_IDLE) && !flush;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;

  // Decode the incoming request into magnitudes, signs and special cases.
  always_comb begin
    // MULH* on words runs as MULW.
    eff_op   = (is_word_opt && !op_is_div(op)) ? `MDU_MUL : op;
    a_sgn    = op1_signed(eff_op);
    b_sgn    = op2_signed(eff_op);
    a_ext    = is_word_opt ? word_ext(op1, a_sgn) : op1;
    b_ext    = is_word_opt ? word_ext(op2, b_sgn) : op2;
    a_neg    = a_sgn & a_ext[XLEN-1];
    b_neg    = b_sgn & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    min_n    = is_word_opt ? word_ext(XLEN'(1) << (WORD_W - 1), 1'b1)
                           : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_ext == '0);
    div_ovf  = a_sgn && (a_ext == min_n) && (b_ext == '1);
    n_iter   = is_word_opt ? CNT_W'(WORD_W) : CNT_W'(XLEN);
    accept   = in_valid && in_ready;
    div_start = accept && op_is_div(eff_op) && !div_zero && !div_ovf;
  end

  // Shift-add step and sign correction of the full-width product.
  always_comb begin
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    mul_prod = neg_q ? -acc_sum : acc_sum;
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_mag, fast_prod;

  // Single-cycle magnitude multiply with sign correction.
  always_comb begin
    fast_a    = {{XLEN{1'b0}}, a_mag};
    fast_b    = {{XLEN{1'b0}}, b_mag};
    fast_mag  = fast_a * fast_b;
    fast_prod = (a_neg ^ b_neg) ? -fast_mag : fast_mag;
  end
`endif

  exe_stage_mdu_div #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (flush),
    .start_i    (div_start),
    .step_i     (state_q == ST_DIV),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .iters_i    (n_iter),
    .quo_o      (div_quo),
    .rem_o      (div_rem),
    .last_o     (div_last)
  );

  // Select quotient or remainder and apply the latched sign.
  always_comb begin
    div_raw = op_is_rem(op_q) ? div_rem : div_quo;
    div_res = neg_q ? -div_raw : div_raw;
  end

  // FSM next state, datapath loads and result capture.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    op_d        = op_q;
    word_d      = word_q;
    neg_d       = neg_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    mcnt_d      = mcnt_q;
    if (flush) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_d   = eff_op;
            word_d = is_word_opt;
            // Remainder takes the dividend's sign; everything else the XOR.
            neg_d  = op_is_rem(eff_op) ? a_neg : (a_neg ^ b_neg);
            if (!op_is_div(eff_op)) begin
`ifdef MDU_FAST_MUL_EN
              result_d    = fmt_result(mul_pick(fast_prod, eff_op), is_word_opt);
              out_valid_d = 1'b1;
              state_d     = ST_DONE;
`else
              acc_d    = '0;
              mcand_d  = {{XLEN{1'b0}}, a_mag};
              mplier_d = b_mag;
              mcnt_d   = n_iter;
              state_d  = ST_MUL;
`endif
            end else if (div_zero) begin
              result_d    = fmt_result(op_is_rem(eff_op) ? a_ext : '1, is_word_opt);
              out_valid_d = 1'b1;
              state_d     = ST_DONE;
            end else if (div_ovf) begin
              result_d    = fmt_result(op_is_rem(eff_op) ? '0 : a_ext, is_word_opt);
              out_valid_d = 1'b1;
              state_d     = ST_DONE;
            end else begin
              state_d = ST_DIV;
            end
          end
        end
        ST_MUL: begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          mcnt_d   = mcnt_q - CNT_W'(1);
          if (mcnt_q == CNT_W'(1)) begin
            result_d    = fmt_result(mul_pick(mul_prod, op_q), word_q);
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end
        end
        ST_DIV: begin
          if (div_last) begin
            result_d    = fmt_result(div_res, word_q);
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control state and architectural outputs; rst overrides flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  // Operand/iteration registers, loaded on accept before they are read.
  always_ff @(posedge clk) begin
    op_q     <= op_d;
    word_q   <= word_d;
    neg_q    <= neg_d;
    acc_q    <= acc_d;
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    mcnt_q   <= mcnt_d;
  end

endmodule

// File: tb/tb_exe_stage_mdu.sv
// Self-checking bench for exe_stage_mdu (XLEN=64, WORD_W=32): reference
// model feeds a scoreboard queue; results and latencies are compared when
// out_valid rises. Covers directed cases, random ops, backpressure, flush, rst.
module tb_exe_stage_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op_s;
  logic        is_word;
  logic [63:0] op1_s, op2_s;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  exe_stage_mdu #(.XLEN(64), .WORD_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op_s),
    .is_word_opt (is_word),
    .op1         (op1_s),
    .op2         (op2_s),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mdu(input logic [2:0] o, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb_v;
    logic [63:0]        ua, ub, r, mn;
    logic [127:0]       ea, eb, p;
    if (w) begin
      sa = {{32{a[31]}}, a[31:0]};
      sb_v = {{32{b[31]}}, b[31:0]};
      ua = {32'b0, a[31:0]};
      ub = {32'b0, b[31:0]};
      mn = 64'hFFFF_FFFF_8000_0000;
    end else begin
      sa = a; sb_v = b; ua = a; ub = b;
      mn = 64'h8000_0000_0000_0000;
    end
    r = '0;
    if (o < 3'd4) begin
      ea = (o == 3'd3) ? {64'b0, a} : {{64{a[63]}}, a};
      eb = (o == 3'd0 || o == 3'd1) ? {{64{b[63]}}, b} : {64'b0, b};
      p  = ea * eb;
      r  = (o == 3'd0 || w) ? p[63:0] : p[127:64];
    end else if (o == 3'd4) begin
      if (sb_v == 0)                                   r = '1;
      else if (sa == $signed(mn) && sb_v == -64'sd1)   r = sa;
      else                                             r = sa / sb_v;
    end else if (o == 3'd5) begin
      if (ub == 0) r = '1;
      else         r = ua / ub;
    end else if (o == 3'd6) begin
      if (sb_v == 0)                                   r = sa;
      else if (sa == $signed(mn) && sb_v == -64'sd1)   r = '0;
      else                                             r = sa % sb_v;
    end else begin
      if (ub == 0) r = ua;
      else         r = ua % ub;
    end
    if (w) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    if (o < 3'd4) begin
`ifdef MDU_FAST_MUL_EN
      return 1;
`else
      return w ? 33 : 65;
`endif
    end
    zero = w ? (b[31:0] == 32'h0) : (b == 64'h0);
    ovf  = (o == 3'd4 || o == 3'd6) &&
           (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
              : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
    return (zero || ovf) ? 1 : (w ? 33 : 65);
  endfunction

  // Present a request and leave the bench #1 after the accept edge.
  task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input bit track);
    exp_t e;
    int   waitc = 0;
    while (!in_ready && waitc < 200) begin
      @(posedge clk); #1;
      waitc++;
    end
    check("in_ready_before_issue", in_ready, 1'b1);
    in_valid = 1'b1; op_s = o; is_word = w; op1_s = a; op2_s = b;
    if (track) begin
      e.res = ref_mdu(o, w, a, b);
      e.lat = ref_lat(o, w, a, b);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid, then compare result and latency against the scoreboard.
  task automatic collect(input string tag, output logic [63:0] exp_res);
    exp_t e;
    int   lat = 1;
    exp_res = '0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_valid"}, out_valid, 1'b1);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_scoreboard: got empty queue expected one entry", tag);
    end else begin
      e = sb.pop_front();
      exp_res = e.res;
      check({tag, "_result"}, result, e.res);
      check({tag, "_latency"}, 64'(lat), 64'(e.lat));
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic w,
                        input logic [63:0] a, input logic [63:0] b);
    logic [63:0] er;
    issue(o, w, a, b, 1'b1);
    collect(tag, er);
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 64'(int'($urandom_range(0, 200)) - 100);
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h8000_0000_0000_0000;
      3:       return {32'h0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] er;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op_s = '0; is_word = 1'b0;
    op1_s = '0; op2_s = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_result", result, 64'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);

    // Directed cases.
    run_op("div_neg7_2",  3'd4, 1'b0, -64'sd7, 64'd2);
    run_op("rem_neg7_2",  3'd6, 1'b0, -64'sd7, 64'd2);
    run_op("mulhu_ones",  3'd3, 1'b0, '1, '1);
    run_op("mul_ones",    3'd0, 1'b0, '1, '1);
    run_op("divw_ovf",    3'd4, 1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF);
    run_op("divu_zero",   3'd5, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0);
    run_op("remu_zero",   3'd7, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0);
    run_op("mulw_7fff",   3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2);
    run_op("div_ovf64",   3'd4, 1'b0, 64'h8000_0000_0000_0000, '1);
    run_op("mulhsu_neg",  3'd2, 1'b0, -64'sd3, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("mulhw_as_mulw", 3'd1, 1'b1, 64'h0000_0000_8000_0000, 64'd3);
    run_op("remw_neg",    3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2);

    // Random ops through the scoreboard.
    for (int i = 0; i < 24; i++) begin
      run_op("random", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             pick_operand(), pick_operand());
    end

    // Backpressure: result and handshake held while out_ready is low.
    out_ready = 1'b0;
    issue(3'd3, 1'b0, '1, '1, 1'b1);
    collect("bp", er);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_result_hold", result, er);
      check("bp_valid_hold", out_valid, 1'b1);
      check("bp_in_ready_low", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_busy", busy, 1'b0);
    check("bp_release_in_ready", in_ready, 1'b1);
    check("bp_release_valid", out_valid, 1'b0);

    // Flush at iteration 20 of a DIV with a request offered in the flush cycle.
    issue(3'd4, 1'b0, 64'd1000000, 64'd3, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    check("kill_busy", busy, 1'b1);
    check("kill_no_valid", out_valid, 1'b0);
    flush = 1'b1; in_valid = 1'b1; op_s = 3'd5; is_word = 1'b0;
    op1_s = 64'd100; op2_s = 64'd7;
    #1 check("flush_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_idle_busy", busy, 1'b0);
    check("flush_out_valid", out_valid, 1'b0);
    run_op("after_flush", 3'd5, 1'b0, 64'd100, 64'd7);

    // Reset mid-DIV returns every output to its reset value.
    issue(3'd4, 1'b0, -64'sd1000, 64'd7, 1'b0);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, 64'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    run_op("after_rst", 3'd4, 1'b0, -64'sd7, 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
